// File: rtl/jb_prach_fft_framer_pkg.sv
// Shared types and constants for the PRACH FFT framer.
// Pulled into the framer and its bench with import jb_prach_pkg::*.
package jb_prach_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      SKIP_CP,
      COLLECT
   } framer_state_t;

   localparam int MAX_NUM_REP = 4;

   // A single antenna still needs a 1-bit tuser field.
   function automatic int usr_id_bw(input int num_ant);
      return (num_ant > 1) ? $clog2(num_ant) : 1;
   endfunction

endpackage

// File: rtl/jb_prach_fft_framer_if.sv
// AXI4-Stream style bus used on both sides of the PRACH FFT framer.
interface jb_axi4_stream_if #(
   parameter int DATA_W = 32,
   parameter int USER_W = 2
) ();

   logic                  tvalid;
   logic                  tready;
   logic [DATA_W-1:0]     tdata;
   logic [USER_W-1:0]     tuser;
   logic                  tlast;
   logic [DATA_W/8-1:0]   tkeep;

   modport master (
      output tvalid, tdata, tuser, tlast, tkeep,
      input  tready
   );

   modport slave (
      input  tvalid, tdata, tuser, tlast, tkeep,
      output tready
   );

endinterface

// File: rtl/jb_prach_fft_framer_fifo.sv
// Synchronous first-word-fall-through FIFO; flush wins over push and pop.
// A pop in the same cycle frees a slot, so push and pop together at full is accepted.
module jb_sync_fifo_fwft #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

endmodule

// File: rtl/jb_prach_fft_framer.sv
// Cuts the aligned antenna-TDM PRACH stream into FFT frames, dropping CP rounds,
// and buffers the frames so the FFT core can backpressure a source that cannot stall.
module jb_prach_fft_framer
   import jb_prach_pkg::*;
#(
   parameter int NUM_ANT    = 4,
   parameter int USR_ID_BW  = usr_id_bw(NUM_ANT),
   parameter int PRECISION  = 16,
   parameter int CNT_BW     = 12,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              car_en,
   input  logic              frm_mrkr,
   input  logic [CNT_BW-1:0] cfg_fft_len,
   input  logic [CNT_BW-1:0] cfg_cp_len,
   input  logic [2:0]        cfg_num_rep,
   input  logic              err_clr,
   jb_axi4_stream_if.slave   IFP_fft_in,
   jb_axi4_stream_if.master  IFP_fft_out,
   output logic              seq_err,
   output logic              ovf,
   output logic              cfg_err
);

   localparam int DW = 2 * PRECISION;
   localparam int FW = DW + USR_ID_BW + 1;

   typedef logic [USR_ID_BW-1:0] ant_t;
   typedef logic [CNT_BW-1:0]    cnt_t;

   localparam ant_t LAST_ANT = ant_t'(NUM_ANT - 1);

   framer_state_t state;
   cnt_t          fft_len_q;
   cnt_t          cp_len_q;
   logic [2:0]    num_rep_q;
   ant_t          ant_idx;
   cnt_t          round;
   logic [2:0]    rep_cnt;

   logic          stage_vld;
   logic [DW-1:0] stage_data;
   ant_t          stage_user;
   logic          stage_last;

   logic          fifo_full;
   logic          fifo_empty;
   logic          fifo_pop;
   logic [FW-1:0] fifo_head;

   logic          in_vld;
   logic          is_idle;
   logic          arm;
   logic          cfg_ok;
   cnt_t          fft_e;
   cnt_t          cp_e;
   logic [2:0]    rep_e;
   logic          start;
   framer_state_t run_state;
   ant_t          run_ant;
   cnt_t          run_round;
   logic [2:0]    run_rep;
   logic          active;
   logic          mis;
   logic          beat_ok;
   logic          last_ant;
   logic          cp_done;
   logic          frame_end;
   logic          occ_end;
   logic          keep;
   logic          abort;
   logic          flush;
   logic          ovf_evt;

   assign in_vld  = clk_en & IFP_fft_in.tvalid;
   assign is_idle = (state == IDLE);
   assign arm     = is_idle & clk_en & car_en & frm_mrkr;
   assign cfg_ok  = (cfg_fft_len != '0) && (cfg_num_rep != '0) &&
                    (cfg_num_rep <= 3'(MAX_NUM_REP));

   // In the arming cycle the fresh cfg is live, so the start beat may share that cycle.
   assign fft_e = is_idle ? cfg_fft_len : fft_len_q;
   assign cp_e  = is_idle ? cfg_cp_len  : cp_len_q;
   assign rep_e = is_idle ? cfg_num_rep : num_rep_q;

   assign start = in_vld & car_en & (IFP_fft_in.tuser == '0) &
                  ((state == ARMED) | (arm & cfg_ok));

   // The start beat is handled as round 0, beat 0 of whichever phase comes next.
   assign run_state = start ? ((cp_e != '0) ? SKIP_CP : COLLECT) : state;
   assign run_ant   = start ? '0 : ant_idx;
   assign run_round = start ? '0 : round;
   assign run_rep   = start ? '0 : rep_cnt;

   assign active    = in_vld & car_en & ((run_state == SKIP_CP) | (run_state == COLLECT));
   assign mis       = active & (IFP_fft_in.tuser != run_ant);
   assign beat_ok   = active & ~mis;
   assign last_ant  = (run_ant == LAST_ANT);
   assign cp_done   = last_ant & (run_round == cp_e - cnt_t'(1));
   assign frame_end = last_ant & (run_round == fft_e - cnt_t'(1));
   assign occ_end   = frame_end & (run_rep == rep_e - 3'd1);
   assign keep      = beat_ok & (run_state == COLLECT);

   assign abort    = clk_en & ~car_en & ~is_idle;
   assign flush    = abort | mis;
   assign fifo_pop = ~fifo_empty & IFP_fft_out.tready;
   assign ovf_evt  = stage_vld & fifo_full & ~fifo_pop & ~flush;

   // Framing state, input stage register and sticky flags; an error beats a same-cycle clear.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         fft_len_q  <= '0;
         cp_len_q   <= '0;
         num_rep_q  <= '0;
         ant_idx    <= '0;
         round      <= '0;
         rep_cnt    <= '0;
         stage_vld  <= 1'b0;
         stage_data <= '0;
         stage_user <= '0;
         stage_last <= 1'b0;
         seq_err    <= 1'b0;
         ovf        <= 1'b0;
         cfg_err    <= 1'b0;
      end else begin
         stage_vld <= keep;
         if (in_vld) begin
            stage_data <= IFP_fft_in.tdata;
            stage_user <= IFP_fft_in.tuser;
            stage_last <= frame_end;
         end

         seq_err <= mis | (seq_err & ~err_clr);
         ovf     <= ovf_evt | (ovf & ~err_clr);
         cfg_err <= (arm & ~cfg_ok) | (cfg_err & ~err_clr);

         if (arm) begin
            fft_len_q <= cfg_fft_len;
            cp_len_q  <= cfg_cp_len;
            num_rep_q <= cfg_num_rep;
         end

         if (abort || mis) begin
            state   <= IDLE;
            ant_idx <= '0;
            round   <= '0;
            rep_cnt <= '0;
         end else if (beat_ok) begin
            state   <= run_state;
            ant_idx <= last_ant ? '0 : run_ant + ant_t'(1);
            round   <= run_round;
            rep_cnt <= run_rep;
            if (last_ant) begin
               if (run_state == SKIP_CP) begin
                  if (cp_done) begin
                     round <= '0;
                     state <= COLLECT;
                  end else begin
                     round <= run_round + cnt_t'(1);
                  end
               end else if (frame_end) begin
                  round <= '0;
                  if (occ_end) begin
                     rep_cnt <= '0;
                     state   <= IDLE;
                  end else begin
                     rep_cnt <= run_rep + 3'd1;
                  end
               end else begin
                  round <= run_round + cnt_t'(1);
               end
            end
         end else if (arm && cfg_ok) begin
            state <= ARMED;
         end
      end
   end

   jb_sync_fifo_fwft #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (stage_vld),
      .pop   (fifo_pop),
      .flush (flush),
      .wdata ({stage_last, stage_user, stage_data}),
      .rdata (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign IFP_fft_in.tready  = 1'b1;
   assign IFP_fft_out.tvalid = ~fifo_empty;
   assign IFP_fft_out.tdata  = fifo_empty ? '0   : fifo_head[DW-1:0];
   assign IFP_fft_out.tuser  = fifo_empty ? '0   : fifo_head[DW +: USR_ID_BW];
   assign IFP_fft_out.tlast  = fifo_empty ? 1'b0 : fifo_head[FW-1];
   assign IFP_fft_out.tkeep  = '1;

endmodule

// File: tb/tb_jb_prach_fft_framer.sv
// Directed bench for the PRACH FFT framer with a small output FIFO (depth 8).
module tb_jb_prach_fft_framer;
   import jb_prach_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        clk_en;
   logic        car_en;
   logic        frm_mrkr;
   logic [11:0] cfg_fft_len;
   logic [11:0] cfg_cp_len;
   logic [2:0]  cfg_num_rep;
   logic        err_clr;
   logic        seq_err;
   logic        ovf;
   logic        cfg_err;

   int vec_cnt = 0;
   int mis_cnt = 0;

   logic [31:0] cap_data [$];
   logic [1:0]  cap_user [$];
   logic        cap_last [$];

   jb_axi4_stream_if #(.DATA_W(32), .USER_W(2)) s_in  ();
   jb_axi4_stream_if #(.DATA_W(32), .USER_W(2)) s_out ();

   jb_prach_fft_framer #(
      .NUM_ANT    (4),
      .USR_ID_BW  (2),
      .PRECISION  (16),
      .CNT_BW     (12),
      .FIFO_DEPTH (8)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .clk_en      (clk_en),
      .car_en      (car_en),
      .frm_mrkr    (frm_mrkr),
      .cfg_fft_len (cfg_fft_len),
      .cfg_cp_len  (cfg_cp_len),
      .cfg_num_rep (cfg_num_rep),
      .err_clr     (err_clr),
      .IFP_fft_in  (s_in),
      .IFP_fft_out (s_out),
      .seq_err     (seq_err),
      .ovf         (ovf),
      .cfg_err     (cfg_err)
   );

   always #5 clk = ~clk;

   // Record every output handshake half a cycle before the edge that completes it.
   always @(negedge clk) begin
      if (!reset && s_out.tvalid && s_out.tready) begin
         cap_data.push_back(s_out.tdata);
         cap_user.push_back(s_out.tuser);
         cap_last.push_back(s_out.tlast);
      end
   end

   task automatic do_reset();
      reset        = 1'b1;
      clk_en       = 1'b1;
      car_en       = 1'b1;
      frm_mrkr     = 1'b0;
      err_clr      = 1'b0;
      cfg_fft_len  = 12'd4;
      cfg_cp_len   = 12'd0;
      cfg_num_rep  = 3'd1;
      s_in.tvalid  = 1'b0;
      s_in.tdata   = '0;
      s_in.tuser   = '0;
      s_in.tlast   = 1'b0;
      s_in.tkeep   = '1;
      s_out.tready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      cap_data.delete();
      cap_user.delete();
      cap_last.delete();
   endtask

   task automatic drive_beat(input logic [31:0] d, input logic [1:0] u, input logic m);
      s_in.tvalid = 1'b1;
      s_in.tdata  = d;
      s_in.tuser  = u;
      frm_mrkr    = m;
      @(posedge clk);
      #1;
      s_in.tvalid = 1'b0;
      frm_mrkr    = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      vec_cnt++;
      if (s_out.tvalid !== 1'b0 || s_out.tdata !== 32'h0 || s_out.tuser !== 2'h0 || s_out.tlast !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL reset_out: got v=%b d=%h u=%h l=%b expected all zero", s_out.tvalid, s_out.tdata, s_out.tuser, s_out.tlast);
      end
      vec_cnt++;
      if (s_out.tkeep !== 4'hF || s_in.tready !== 1'b1) begin
         mis_cnt++;
         $display("[TB] FAIL reset_keep_rdy: got tkeep=%h tready=%b expected F 1", s_out.tkeep, s_in.tready);
      end
      vec_cnt++;
      if ({seq_err, ovf, cfg_err} !== 3'b000 || dut.state !== IDLE) begin
         mis_cnt++;
         $display("[TB] FAIL reset_flags: got flags=%b state=%0d expected 000 0", {seq_err, ovf, cfg_err}, dut.state);
      end
   endtask

   task automatic test_cp_skip();
      do_reset();
      cfg_fft_len = 12'd4;
      cfg_cp_len  = 12'd2;
      cfg_num_rep = 3'd1;
      for (int i = 0; i < 28; i++) begin
         drive_beat({16'd1, 16'(i)}, 2'(i % 4), i == 0);
         if (i == 8) begin
            vec_cnt++;
            if (s_out.tvalid !== 1'b0) begin
               mis_cnt++;
               $display("[TB] FAIL cp_latency_early: got tvalid=%b expected 0", s_out.tvalid);
            end
         end
         if (i == 9) begin
            vec_cnt++;
            if (s_out.tvalid !== 1'b1 || s_out.tdata !== {16'd1, 16'd8}) begin
               mis_cnt++;
               $display("[TB] FAIL cp_latency_first: got v=%b d=%h expected 1 00010008", s_out.tvalid, s_out.tdata);
            end
         end
      end
      repeat (6) @(posedge clk);
      #1;
      vec_cnt++;
      if (cap_data.size() != 16) begin
         mis_cnt++;
         $display("[TB] FAIL cp_count: got %0d expected 16", cap_data.size());
      end
      for (int k = 0; k < 16; k++) begin
         if (k < cap_data.size()) begin
            vec_cnt++;
            if (cap_data[k] !== {16'd1, 16'(8 + k)} || cap_last[k] !== (k == 15)) begin
               mis_cnt++;
               $display("[TB] FAIL cp_beat%0d: got d=%h l=%b expected %h %b", k, cap_data[k], cap_last[k], {16'd1, 16'(8 + k)}, k == 15);
            end
         end
      end
      vec_cnt++;
      if (dut.state !== IDLE || s_out.tvalid !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL cp_end_idle: got state=%0d tvalid=%b expected 0 0", dut.state, s_out.tvalid);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      cfg_fft_len = 12'd2;
      cfg_cp_len  = 12'd0;
      cfg_num_rep = 3'd3;
      for (int i = 0; i < 28; i++) begin
         drive_beat({16'd2, 16'(i)}, 2'(i % 4), i == 0);
      end
      repeat (6) @(posedge clk);
      #1;
      vec_cnt++;
      if (cap_data.size() != 24 || dut.state !== IDLE) begin
         mis_cnt++;
         $display("[TB] FAIL rep_count: got n=%0d state=%0d expected 24 0", cap_data.size(), dut.state);
      end
      for (int k = 0; k < 24; k++) begin
         if (k < cap_data.size()) begin
            vec_cnt++;
            if (cap_data[k] !== {16'd2, 16'(k)} || cap_last[k] !== (k % 8 == 7)) begin
               mis_cnt++;
               $display("[TB] FAIL rep_beat%0d: got d=%h l=%b expected %h %b", k, cap_data[k], cap_last[k], {16'd2, 16'(k)}, k % 8 == 7);
            end
         end
      end
      cap_data.delete();
      cap_user.delete();
      cap_last.delete();
      for (int i = 0; i < 8; i++) begin
         drive_beat({16'd3, 16'(i)}, 2'(i % 4), i == 0);
      end
      repeat (6) @(posedge clk);
      #1;
      vec_cnt++;
      if (cap_data.size() != 8 || dut.state !== COLLECT) begin
         mis_cnt++;
         $display("[TB] FAIL restart_count: got n=%0d state=%0d expected 8 3", cap_data.size(), dut.state);
      end
      if (cap_data.size() == 8) begin
         vec_cnt++;
         if (cap_data[0] !== {16'd3, 16'd0} || cap_last[7] !== 1'b1 || cap_last[3] !== 1'b0) begin
            mis_cnt++;
            $display("[TB] FAIL restart_frame: got d0=%h l3=%b l7=%b expected 00030000 0 1", cap_data[0], cap_last[3], cap_last[7]);
         end
      end
   endtask

   task automatic test_misaligned();
      do_reset();
      cfg_fft_len = 12'd1;
      cfg_cp_len  = 12'd0;
      cfg_num_rep = 3'd1;
      for (int i = 0; i < 8; i++) begin
         drive_beat({16'd4, 16'(i)}, 2'((i + 2) % 4), i == 0);
      end
      repeat (6) @(posedge clk);
      #1;
      vec_cnt++;
      if (cap_data.size() != 4 || seq_err !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL align_count: got n=%0d seq_err=%b expected 4 0", cap_data.size(), seq_err);
      end
      for (int k = 0; k < 4; k++) begin
         if (k < cap_data.size()) begin
            vec_cnt++;
            if (cap_data[k] !== {16'd4, 16'(k + 2)} || cap_user[k] !== 2'(k) || cap_last[k] !== (k == 3)) begin
               mis_cnt++;
               $display("[TB] FAIL align_beat%0d: got d=%h u=%0d l=%b expected %h %0d %b", k, cap_data[k], cap_user[k], cap_last[k], {16'd4, 16'(k + 2)}, k, k == 3);
            end
         end
      end
   endtask

   task automatic test_seq_err();
      do_reset();
      cfg_fft_len  = 12'd4;
      cfg_cp_len   = 12'd0;
      cfg_num_rep  = 3'd1;
      s_out.tready = 1'b0;
      drive_beat({16'd5, 16'd0}, 2'd0, 1'b1);
      drive_beat({16'd5, 16'd1}, 2'd1, 1'b0);
      vec_cnt++;
      if (s_out.tvalid !== 1'b1 || s_out.tdata !== {16'd5, 16'd0}) begin
         mis_cnt++;
         $display("[TB] FAIL seq_pre: got v=%b d=%h expected 1 00050000", s_out.tvalid, s_out.tdata);
      end
      drive_beat({16'd5, 16'd2}, 2'd3, 1'b0);
      vec_cnt++;
      if (s_out.tvalid !== 1'b0 || seq_err !== 1'b1 || dut.state !== IDLE) begin
         mis_cnt++;
         $display("[TB] FAIL seq_flush: got v=%b seq_err=%b state=%0d expected 0 1 0", s_out.tvalid, seq_err, dut.state);
      end
      repeat (2) @(posedge clk);
      #1;
      vec_cnt++;
      if (seq_err !== 1'b1 || s_out.tvalid !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL seq_sticky: got seq_err=%b v=%b expected 1 0", seq_err, s_out.tvalid);
      end
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      vec_cnt++;
      if (seq_err !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL seq_clear: got %b expected 0", seq_err);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      cfg_fft_len  = 12'd4;
      cfg_cp_len   = 12'd0;
      cfg_num_rep  = 3'd1;
      s_out.tready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         drive_beat({16'd6, 16'(i)}, 2'(i % 4), i == 0);
         if (i == 8) begin
            vec_cnt++;
            if (ovf !== 1'b0) begin
               mis_cnt++;
               $display("[TB] FAIL ovf_early: got %b expected 0", ovf);
            end
         end
      end
      vec_cnt++;
      if (ovf !== 1'b1) begin
         mis_cnt++;
         $display("[TB] FAIL ovf_set: got %b expected 1", ovf);
      end
      @(posedge clk);
      #1;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
      vec_cnt++;
      if (ovf !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL ovf_clear: got %b expected 0", ovf);
      end
      drive_beat({16'd6, 16'd10}, 2'd2, 1'b0);
      s_out.tready = 1'b1;
      @(posedge clk);
      #1;
      vec_cnt++;
      if (ovf !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL ovf_push_pop_full: got %b expected 0", ovf);
      end
      repeat (12) @(posedge clk);
      #1;
      vec_cnt++;
      if (cap_data.size() != 9) begin
         mis_cnt++;
         $display("[TB] FAIL ovf_count: got %0d expected 9", cap_data.size());
      end
      for (int k = 0; k < 9; k++) begin
         if (k < cap_data.size()) begin
            vec_cnt++;
            if (cap_data[k] !== {16'd6, 16'((k == 8) ? 10 : k)}) begin
               mis_cnt++;
               $display("[TB] FAIL ovf_beat%0d: got %h expected %h", k, cap_data[k], {16'd6, 16'((k == 8) ? 10 : k)});
            end
         end
      end
   endtask

   task automatic test_car_en_cfg();
      do_reset();
      cfg_fft_len  = 12'd4;
      cfg_cp_len   = 12'd0;
      cfg_num_rep  = 3'd1;
      s_out.tready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         drive_beat({16'd7, 16'(i)}, 2'(i), i == 0);
      end
      vec_cnt++;
      if (s_out.tvalid !== 1'b1 || dut.state !== COLLECT) begin
         mis_cnt++;
         $display("[TB] FAIL caren_pre: got v=%b state=%0d expected 1 3", s_out.tvalid, dut.state);
      end
      car_en = 1'b0;
      @(posedge clk);
      #1;
      vec_cnt++;
      if (s_out.tvalid !== 1'b0 || dut.state !== IDLE) begin
         mis_cnt++;
         $display("[TB] FAIL caren_abort: got v=%b state=%0d expected 0 0", s_out.tvalid, dut.state);
      end
      car_en = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if (s_out.tvalid !== 1'b0) begin
         mis_cnt++;
         $display("[TB] FAIL caren_stay_empty: got %b expected 0", s_out.tvalid);
      end
      cfg_fft_len = 12'd0;
      drive_beat({16'd8, 16'd0}, 2'd0, 1'b1);
      vec_cnt++;
      if (cfg_err !== 1'b1 || dut.state !== IDLE) begin
         mis_cnt++;
         $display("[TB] FAIL cfg_err_set: got cfg_err=%b state=%0d expected 1 0", cfg_err, dut.state);
      end
      for (int i = 1; i < 4; i++) begin
         drive_beat({16'd8, 16'(i)}, 2'(i), 1'b0);
      end
      repeat (3) @(posedge clk);
      #1;
      vec_cnt++;
      if (s_out.tvalid !== 1'b0 || dut.state !== IDLE || cfg_err !== 1'b1) begin
         mis_cnt++;
         $display("[TB] FAIL cfg_err_idle: got v=%b state=%0d cfg_err=%b expected 0 0 1", s_out.tvalid, dut.state, cfg_err);
      end
   endtask

   initial begin
      test_reset();
      test_cp_skip();
      test_back_to_back();
      test_misaligned();
      test_seq_err();
      test_overflow();
      test_car_en_cfg();
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, mis_cnt);
      $finish;
   end

endmodule
